sdram_pixel_unpacker: RTL and testbench

Read-side counterpart of the camera write arbitrator. It pulls packed 16-bit word pairs from the SDRAM read FIFOs and rebuilds 8-bit R, G and B plus the embedded 8-bit gray byte. Each pixel is presented to the LCD path with raster coordinates. It tracks frame progress and substitutes black pixels on FIFO underflow.

---
 rtl/sdram_pixel_unpacker_if.sv | 11 +
 rtl/sdram_pixel_unpacker.sv | 164 ++++++++++++++++
 tb/tb_sdram_pixel_unpacker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pixel_unpacker_if.sv
// Read port of the paired SDRAM read FIFOs: one pop strobe, a shared empty flag and two 16-bit words.
// The unpacker owns the pop strobe; the FIFO side returns data a fixed number of cycles later.
interface sdram_pixel_unpacker_if;
    logic        rdReq;
    logic        rdEmpty;
    logic [15:0] rd1Data;
    logic [15:0] rd2Data;

    modport master (output rdReq, input rdEmpty, input rd1Data, input rd2Data);
    modport slave  (input rdReq, output rdEmpty, output rd1Data, output rd2Data);
endinterface

// File: rtl/sdram_pixel_unpacker.sv
// Rebuilds RGB888 + gray from SDRAM word pairs with raster coordinates; GRAY_VIEW_EN adds iGray_view (gray on RGB).
// Latency RD_LAT+1 from iReq to oPix_valid.
// No backpressure: every iReq yields one pixel; an empty FIFO yields a black pixel and sets oUnderflow.
module sdram_pixel_unpacker #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int RD_LAT   = 1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iFrame_start,
    input  logic        iReq,
`ifdef GRAY_VIEW_EN
    input  logic        iGray_view,
`endif
    sdram_pixel_unpacker_if.master rd,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic [7:0]  oGray,
    output logic        oPix_valid,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oUnderflow,
    output logic        oFrame_done
);

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic        vld;
        logic        sub;
        logic        last;
        logic        gv;
        logic [15:0] x;
        logic [15:0] y;
    } tag_t;

    state_t      state, stateNxt;
    logic [15:0] xCnt, yCnt, xNxt, yNxt, reqX, reqY;
    logic        reqActive, atEnd, underNxt;
    tag_t        tagIn, tagOut;
    tag_t        tagPipe [RD_LAT];
    logic [7:0]  unpR, unpG, unpB, unpGray;

    // A start pulse is applied before the same-cycle request, which becomes pixel (0,0).
    always_comb begin
        stateNxt  = state;
        reqX      = xCnt;
        reqY      = yCnt;
        xNxt      = xCnt;
        yNxt      = yCnt;
        underNxt  = oUnderflow;
        reqActive = 1'b0;
        atEnd     = 1'b0;
        tagIn     = '0;

        if (iFrame_start) begin
            stateNxt = ACTIVE;
            reqX     = '0;
            reqY     = '0;
            xNxt     = '0;
            yNxt     = '0;
            underNxt = 1'b0;
        end

        reqActive = iReq && (iFrame_start || state == ACTIVE);
        atEnd     = (reqX == X_LAST) && (reqY == Y_LAST);

        if (reqActive) begin
            if (atEnd) begin
                stateNxt = DONE;
                xNxt     = reqX;
                yNxt     = reqY;
            end else if (reqX == X_LAST) begin
                xNxt = '0;
                yNxt = reqY + 16'd1;
            end else begin
                xNxt = reqX + 16'd1;
                yNxt = reqY;
            end
            if (rd.rdEmpty) underNxt = 1'b1;
        end

        // Outside ACTIVE the counters hold the last coordinate, so idle black pixels keep oX/oY steady.
        tagIn.vld  = iReq;
        tagIn.sub  = !(reqActive && !rd.rdEmpty);
        tagIn.last = reqActive && atEnd;
        tagIn.x    = reqX;
        tagIn.y    = reqY;
`ifdef GRAY_VIEW_EN
        tagIn.gv   = iGray_view;
`else
        tagIn.gv   = 1'b0;
`endif
    end

    assign rd.rdReq = iRst_n && reqActive && !rd.rdEmpty;
    assign tagOut   = tagPipe[RD_LAT-1];

    assign unpR    = rd.rd2Data[9:2];
    assign unpG    = {rd.rd1Data[14:10], rd.rd2Data[14:12]};
    assign unpB    = rd.rd1Data[9:2];
    assign unpGray = {rd.rd1Data[15], rd.rd1Data[1:0], rd.rd2Data[15],
                      rd.rd2Data[11:10], rd.rd2Data[1:0]};

    always_ff @(posedge iClk) begin
        if (!iRst_n) state <= WAIT_SOF;
        else         state <= stateNxt;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            xCnt        <= '0;
            yCnt        <= '0;
            oUnderflow  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) tagPipe[i] <= '0;
            oPix_valid  <= 1'b0;
            oR          <= '0;
            oG          <= '0;
            oB          <= '0;
            oGray       <= '0;
            oX          <= '0;
            oY          <= '0;
            oFrame_done <= 1'b0;
        end else begin
            xCnt       <= xNxt;
            yCnt       <= yNxt;
            oUnderflow <= underNxt;
            tagPipe[0] <= tagIn;
            for (int i = 1; i < RD_LAT; i++) tagPipe[i] <= tagPipe[i-1];

            // The oldest tag lines up with the FIFO data returning this cycle.
            if (tagOut.vld) begin
                oPix_valid  <= 1'b1;
                oX          <= tagOut.x;
                oY          <= tagOut.y;
                oFrame_done <= tagOut.last;
                if (tagOut.sub) begin
                    oR    <= '0;
                    oG    <= '0;
                    oB    <= '0;
                    oGray <= '0;
                end else begin
                    oR    <= tagOut.gv ? unpGray : unpR;
                    oG    <= tagOut.gv ? unpGray : unpG;
                    oB    <= tagOut.gv ? unpGray : unpB;
                    oGray <= unpGray;
                end
            end else begin
                oPix_valid  <= 1'b0;
                oFrame_done <= 1'b0;
                oR          <= '0;
                oG          <= '0;
                oB          <= '0;
                oGray       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_pixel_unpacker.sv
// Directed + random bench for sdram_pixel_unpacker against a frame-level pixel model.
module tb_sdram_pixel_unpacker;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int LAT  = 2;
    localparam int MAXC = 2048;
`ifdef GRAY_VIEW_EN
    localparam bit GV_ON = 1'b1;
`else
    localparam bit GV_ON = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        done;
        logic [7:0]  r, g, b, gray;
        logic [15:0] x, y;
    } pix_t;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    logic iFrame_start = 1'b0;
    logic iReq = 1'b0;
`ifdef GRAY_VIEW_EN
    logic iGray_view = 1'b0;
`endif
    logic [7:0]  oR, oG, oB, oGray;
    logic        oPix_valid, oUnderflow, oFrame_done;
    logic [15:0] oX, oY;

    sdram_pixel_unpacker_if rdBus ();

    sdram_pixel_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(LAT)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iFrame_start(iFrame_start), .iReq(iReq),
`ifdef GRAY_VIEW_EN
        .iGray_view(iGray_view),
`endif
        .rd(rdBus), .oR(oR), .oG(oG), .oB(oB), .oGray(oGray), .oPix_valid(oPix_valid),
        .oX(oX), .oY(oY), .oUnderflow(oUnderflow), .oFrame_done(oFrame_done)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: expected output per cycle, FIFO words scheduled per cycle, frame progress as a pixel index.
    pix_t        expAt [MAXC];
    logic        dV [MAXC];
    logic [15:0] d1 [MAXC];
    logic [15:0] d2 [MAXC];
    int          mode = 0;      // 0 waiting for frame, 1 in frame, 2 frame complete
    int          n = 0;
    logic        und = 1'b0, undVis = 1'b0;
    logic [15:0] heldX = '0, heldY = '0, curX = '0, curY = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic pix_t unpack(input logic [15:0] w1, input logic [15:0] w2, input logic gv);
        pix_t p;
        p      = '0;
        p.r    = w2[9:2];
        p.g    = {w1[14:10], w2[14:12]};
        p.b    = w1[9:2];
        p.gray = {w1[15], w1[1:0], w2[15], w2[11:10], w2[1:0]};
        if (gv) begin
            p.r = p.gray;
            p.g = p.gray;
            p.b = p.gray;
        end
        return p;
    endfunction

    task automatic checkOutputs();
        pix_t e;
        if (expAt[cyc].v) begin
            e    = expAt[cyc];
            curX = e.x;
            curY = e.y;
        end else begin
            e   = '0;
            e.x = curX;
            e.y = curY;
        end
        chk("pix_valid", 32'(oPix_valid), 32'(e.v));
        chk("red", 32'(oR), 32'(e.r));
        chk("green", 32'(oG), 32'(e.g));
        chk("blue", 32'(oB), 32'(e.b));
        chk("gray", 32'(oGray), 32'(e.gray));
        chk("x", 32'(oX), 32'(e.x));
        chk("y", 32'(oY), 32'(e.y));
        chk("frame_done", 32'(oFrame_done), 32'(e.done));
        chk("underflow", 32'(oUnderflow), 32'(undVis));
    endtask

    task automatic step(input logic rstN, input logic fs, input logic rq, input logic em,
                        input logic gv, input logic useW, input logic [15:0] w1, input logic [15:0] w2);
        logic        pop, reqAct, gvEff;
        logic [15:0] a, b;
        pix_t        e, p;
        checkOutputs();
        gvEff  = gv & GV_ON;
        iRst_n = rstN;
        iFrame_start = fs;
        iReq   = rq;
        rdBus.rdEmpty = em;
`ifdef GRAY_VIEW_EN
        iGray_view = gv;
`endif
        if (dV[cyc]) begin
            rdBus.rd1Data = d1[cyc];
            rdBus.rd2Data = d2[cyc];
        end else begin
            rdBus.rd1Data = 16'($urandom);
            rdBus.rd2Data = 16'($urandom);
        end
        pop = 1'b0;
        if (!rstN) begin
            mode = 0; n = 0; und = 1'b0;
            heldX = '0; heldY = '0; curX = '0; curY = '0;
            for (int k = cyc + 1; k < MAXC; k++) begin
                expAt[k] = '0;
                dV[k] = 1'b0;
            end
        end else begin
            if (fs) begin
                mode = 1; n = 0; und = 1'b0;
            end
            reqAct = rq && (mode == 1);
            pop = reqAct && !em;
            if (rq) begin
                e = '0;
                e.v = 1'b1;
                if (reqAct) begin
                    e.x = 16'(n % H);
                    e.y = 16'(n / H);
                    heldX = e.x;
                    heldY = e.y;
                    e.done = (n == H * V - 1);
                    n++;
                    if (e.done) mode = 2;
                    if (em) und = 1'b1;
                end else begin
                    e.x = heldX;
                    e.y = heldY;
                end
                if (pop) begin
                    a = useW ? w1 : 16'($urandom);
                    b = useW ? w2 : 16'($urandom);
                    d1[cyc + LAT] = a;
                    d2[cyc + LAT] = b;
                    dV[cyc + LAT] = 1'b1;
                    p = unpack(a, b, gvEff);
                    e.r = p.r; e.g = p.g; e.b = p.b; e.gray = p.gray;
                end
                expAt[cyc + LAT + 1] = e;
            end
        end
        #1;
        chk("rd_req", 32'(rdBus.rdReq), 32'(pop));
        @(posedge iClk);
        @(negedge iClk);
        undVis = und;
        cyc++;
    endtask

    task automatic req(input logic fs, input logic em);
        step(1'b1, fs, 1'b1, em, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int k = 0; k < MAXC; k++) begin
            expAt[k] = '0;
            dV[k] = 1'b0;
        end
        rdBus.rdEmpty = 1'b0;
        rdBus.rd1Data = '0;
        rdBus.rd2Data = '0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);

        // Reset held with requests pending, then idle without a frame start.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(3);

        // Frame start and first request together; known word pair.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAE05, 16'h270F);
        idle(2);
        chk("dir_valid", 32'(oPix_valid), 32'd1);
        chk("dir_r", 32'(oR), 32'h0C3);
        chk("dir_g", 32'(oG), 32'h05A);
        chk("dir_b", 32'(oB), 32'h081);
        chk("dir_gray", 32'(oGray), 32'h0A7);
        chk("dir_xy", {oY, oX}, 32'h0);

        // Rest of the frame back to back, then one request past the end.
        for (int i = 0; i < 7; i++) req(1'b0, 1'b0);
        req(1'b0, 1'b0);
        idle(4);
        chk("done_hold_x", 32'(oX), 32'(H - 1));
        chk("done_hold_y", 32'(oY), 32'(V - 1));

        // Underflow on the third request of a new frame.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        req(1'b0, 1'b0);
        req(1'b0, 1'b0);
        req(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) req(1'b0, 1'b0);
        idle(4);
        chk("underflow_sticky", 32'(oUnderflow), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(1);
        chk("underflow_cleared", 32'(oUnderflow), 32'd0);

        // Mid-frame restart colliding with a request.
        req(1'b0, 1'b0);
        req(1'b0, 1'b1);
        req(1'b1, 1'b0);
        idle(4);

        // Reset with two reads in flight, then a request while waiting for a frame.
        req(1'b1, 1'b0);
        req(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(5);
        req(1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'b0, 16'h0, 16'h0);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
